sha2_msg_sched: RTL and testbench
=================================

SHA2_MSG_SCHED -- requirements
Module: sha2_msg_sched

Interface
REQ-001 SHALL have parameter LOGIC_GATING, default 1: when 1, the sigma datapath inputs are ANDed to zero outside state EXPAND.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port start_i, input, 1 bit: begins a new 512-bit block schedule.
REQ-005 SHALL have port abort_i, input, 1 bit: synchronous cancel of the current schedule.
REQ-006 SHALL have ports in_valid_i (input, 1), in_ready_o (output, 1) and in_word_i (input, 32): message word input stream, big-endian word order M0..M15.
REQ-007 SHALL have ports out_valid_o (output, 1), out_ready_i (input, 1), out_word_o (output, 32) and out_idx_o (output, 6): schedule word output stream W[t] with index t.
REQ-008 SHALL have ports busy_o (output, 1), high in any state other than IDLE, and done_o (output, 1), a single-cycle pulse.

Function
REQ-009 SHALL implement the states IDLE, LOAD and EXPAND.
REQ-010 SHALL use a 7-bit counter t (0..64), a 16-entry x 32-bit shift buffer buf[0..15] and a single output register.
- Transfer: an input transfer occurs when in_valid_i and in_ready_o are both high; an output transfer occurs when out_valid_o and out_ready_i are both high.
REQ-011 IDLE: in_ready_o=0; when start_i=1, SHALL go to LOAD with t=0.
REQ-012 LOAD: in_ready_o SHALL equal (!out_valid_o || out_ready_i).
- On each input transfer: shift in_word_i into buf[15] (buf[i] <= buf[i+1]); load the output register with word=in_word_i, idx=t; t<=t+1.
REQ-013 LOAD SHALL go to EXPAND on the input transfer taken when t=15.
REQ-014 EXPAND: whenever the output register is free (!out_valid_o || out_ready_i), SHALL compute W = sigma1(buf[14]) + buf[9] + sigma0(buf[1]) + buf[0], modulo 2^32.
- With that W: shift it into buf[15], load the output register (idx=t), t<=t+1.
- sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3; sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- One word per cycle under continuous out_ready_i.
REQ-015 Once W63 has been loaded, SHALL stop producing words and SHALL wait for the output transfer of idx 63.
- On that transfer: go to IDLE and pulse done_o=1 in the following cycle; t resets to 0.
REQ-016 While out_valid_o=1 and out_ready_i=0, out_word_o and out_idx_o SHALL hold stable.
- In that condition no buffer shift and no t change occur.
REQ-017 in_ready_o SHALL be 0 in EXPAND and IDLE; in_valid_i is ignored there.
REQ-018 start_i SHALL be ignored while busy_o=1.
REQ-019 abort_i=1 in any state SHALL, next cycle: go to IDLE, clear out_valid_o and t, and suppress done_o.
- abort_i wins over a simultaneous start_i or handshake.
REQ-020 Latency: the first output SHALL be valid the cycle after the input transfer of M0.
- With always-valid input and always-ready output, W63 is valid exactly 64 cycles after M0 is accepted.
REQ-021 Buffer contents SHALL NOT be cleared between blocks; a new LOAD fully overwrites all 16 entries before any expanded word is computed.

Reset
REQ-022 With rst_ni=0 at a clock edge, the block SHALL be in IDLE the next cycle.
- Outputs then: t=0, in_ready_o=0, out_valid_o=0, out_word_o=0, out_idx_o=0, busy_o=0, done_o=0.
REQ-023 Reset mid-schedule SHALL discard the partial block with no done_o pulse; buf contents are don't-care after reset.

Verification
REQ-024 "abc" block (M0=0x61626380, M1..M14=0, M15=0x00000018) with start, continuous valid/ready -> W0..W15 echo the inputs; W16=0x61626380, W17=0x000F0000, W18=0x7DA86405; done_o pulses once, one cycle after the idx-63 transfer; total 64 outputs.
REQ-025 Same block with out_ready_i toggling pseudo-randomly -> identical W sequence and idx order, out_word_o stable across every stall, no word dropped or duplicated.
REQ-026 abort_i asserted at t=30 in EXPAND -> out_valid_o=0 and busy_o=0 next cycle; no done_o; a fresh start then gives correct W16 for the new block.
REQ-027 rst_ni=0 during LOAD at t=7 -> all outputs at reset values next cycle; in_valid_i=1 held afterwards is not accepted until start_i.
REQ-028 start_i pulsed during EXPAND and in the same cycle as done_o -> ignored; block stays IDLE after done_o until the next start_i.

Source files
------------

// File: rtl/sha2_msg_sched.sv
// SHA-256 message schedule generator.
// Accepts the 16 message words of one 512-bit block and streams W[0..63] with their
// indices through a single registered output slot with valid/ready flow control.
module sha2_msg_sched #(
    parameter int unsigned LOGIC_GATING = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_word_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_word_o,
    output logic [5:0]  out_idx_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [1:0] {StIdle, StLoad, StExpand} state_e;

    state_e      state_q;
    logic [6:0]  t_q;
    logic [31:0] sched_q [16];
    logic        out_valid_q;
    logic [31:0] out_word_q;
    logic [5:0]  out_idx_q;
    logic        done_q;

    logic        out_free;
    logic        out_xfer;
    logic        in_xfer;
    logic        gen;
    logic        shift_en;
    logic [31:0] shift_word;
    logic [31:0] gate_mask;
    logic [31:0] s0_in;
    logic [31:0] s1_in;
    logic [31:0] w_new;

    function automatic logic [31:0] sigma0(input logic [31:0] x);
        return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1(input logic [31:0] x);
        return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
    endfunction

    // Handshakes, expansion datapath and the shared shift source.
    always_comb begin
        out_free   = !out_valid_q || out_ready_i;
        out_xfer   = out_valid_q && out_ready_i;
        in_ready_o = (state_q == StLoad) && out_free;
        in_xfer    = in_valid_i && in_ready_o;
        // Holding the sigma inputs at zero outside expansion keeps the XOR trees quiet.
        gate_mask  = ((LOGIC_GATING == 0) || (state_q == StExpand)) ? 32'hFFFF_FFFF : 32'h0;
        s0_in      = sched_q[1] & gate_mask;
        s1_in      = sched_q[14] & gate_mask;
        w_new      = sigma1(s1_in) + sched_q[9] + sigma0(s0_in) + sched_q[0];
        // t_q[6] set means W63 has already been produced.
        gen        = (state_q == StExpand) && out_free && !t_q[6];
        shift_en   = in_xfer || gen;
        shift_word = in_xfer ? in_word_i : w_new;
    end

    // Control FSM and registered output slot; abort overrides everything but reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            t_q         <= 7'd0;
            out_valid_q <= 1'b0;
            out_word_q  <= 32'd0;
            out_idx_q   <= 6'd0;
            done_q      <= 1'b0;
        end else if (abort_i) begin
            state_q     <= StIdle;
            t_q         <= 7'd0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // The done cycle is still IDLE, but a start there is ignored.
                    if (start_i && !done_q) begin
                        state_q <= StLoad;
                        t_q     <= 7'd0;
                    end
                end
                StLoad: begin
                    if (in_xfer) begin
                        out_valid_q <= 1'b1;
                        out_word_q  <= shift_word;
                        out_idx_q   <= t_q[5:0];
                        t_q         <= t_q + 7'd1;
                        if (t_q == 7'd15) begin
                            state_q <= StExpand;
                        end
                    end else if (out_xfer) begin
                        out_valid_q <= 1'b0;
                    end
                end
                StExpand: begin
                    if (gen) begin
                        out_valid_q <= 1'b1;
                        out_word_q  <= shift_word;
                        out_idx_q   <= t_q[5:0];
                        t_q         <= t_q + 7'd1;
                    end else if (out_xfer) begin
                        out_valid_q <= 1'b0;
                        if (out_idx_q == 6'd63) begin
                            state_q <= StIdle;
                            t_q     <= 7'd0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Sixteen-word sliding window; contents are don't-care after reset or abort.
    always_ff @(posedge clk_i) begin
        if (shift_en) begin
            for (int i = 0; i < 15; i++) begin
                sched_q[i] <= sched_q[i+1];
            end
            sched_q[15] <= shift_word;
        end
    end

    // Port outputs.
    always_comb begin
        out_valid_o = out_valid_q;
        out_word_o  = out_word_q;
        out_idx_o   = out_idx_q;
        busy_o      = (state_q != StIdle);
        done_o      = done_q;
    end

endmodule

// File: tb/tb_sha2_msg_sched.sv
// Directed bench for sha2_msg_sched: "abc" block with continuous and stalling output,
// start noise during expansion and on done, abort mid-expansion, reset mid-load.
module tb_sha2_msg_sched;

    logic        clk = 1'b0;
    logic        rst_ni, start, abort, in_valid, in_ready, out_valid, out_ready, busy, done;
    logic [31:0] in_word, out_word;
    logic [5:0]  out_idx;

    int checks = 0;
    int errors = 0;

    logic [31:0] msg   [16];
    logic [31:0] exp_w [64];
    logic [31:0] got   [64];

    always #5 clk = ~clk;

    sha2_msg_sched #(.LOGIC_GATING(1)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start),
        .abort_i     (abort),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_word_i   (in_word),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_word_o  (out_word),
        .out_idx_o   (out_idx),
        .busy_o      (busy),
        .done_o      (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [31:0] ss0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ss1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    task automatic build_model();
        for (int t = 0; t < 16; t++) exp_w[t] = msg[t];
        for (int t = 16; t < 64; t++)
            exp_w[t] = ss1(exp_w[t-2]) + exp_w[t-7] + ss0(exp_w[t-15]) + exp_w[t-16];
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_abc();
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[0]  = 32'h6162_6380;
        msg[15] = 32'h0000_0018;
    endtask

    // One full block: start, feed 16 words, collect 64 outputs, watch done.
    task automatic run_block(input string nm, input bit rand_ready, input bit start_noise);
        int          ni, no, dones, x63, m0, v63;
        bit          stalled;
        logic [31:0] pw;
        logic [5:0]  pi;
        ni = 0; no = 0; dones = 0; x63 = -1; m0 = -1; v63 = -1; stalled = 0;
        pw = 0; pi = 0;
        build_model();
        start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tick();
        start = 1'b0;
        chk({nm, "_busy_after_start"}, 64'(busy), 64'd1);
        for (int c = 0; c < 600; c++) begin
            in_valid = (ni < 16);
            if (ni < 16) in_word = msg[ni];
            out_ready = rand_ready ? ($urandom_range(0, 4) > 1) : 1'b1;
            start = start_noise && ((no == 20) || (done === 1'b1));
            #1;
            if (stalled) begin
                chk({nm, "_stall_valid"}, 64'(out_valid), 64'd1);
                chk({nm, "_stall_word"}, 64'(out_word), 64'(pw));
                chk({nm, "_stall_idx"}, 64'(out_idx), 64'(pi));
            end
            if (out_valid && out_idx == 6'd63 && v63 < 0) v63 = c;
            if (done) begin
                dones++;
                chk({nm, "_done_timing"}, 64'(c), 64'(x63 + 1));
            end
            if (in_valid && in_ready) begin
                if (ni == 0) m0 = c;
                ni++;
            end
            if (out_valid && out_ready) begin
                if (no < 64) begin
                    chk({nm, "_word"}, 64'(out_word), 64'(exp_w[no]));
                    chk({nm, "_idx"}, 64'(out_idx), 64'(no));
                    got[no] = out_word;
                    if (no == 63) x63 = c;
                end else begin
                    chk({nm, "_extra_word"}, 64'(no), 64'd63);
                end
                no++;
            end
            stalled = out_valid && !out_ready;
            pw = out_word;
            pi = out_idx;
            tick();
            if (x63 >= 0 && c >= x63 + 3) break;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk({nm, "_inputs_taken"}, 64'(ni), 64'd16);
        chk({nm, "_outputs"}, 64'(no), 64'd64);
        chk({nm, "_done_count"}, 64'(dones), 64'd1);
        chk({nm, "_idle_after"}, 64'(busy), 64'd0);
        chk({nm, "_ready_idle"}, 64'(in_ready), 64'd0);
        if (!rand_ready) chk({nm, "_w63_latency"}, 64'(v63 - m0), 64'd64);
    endtask

    initial begin
        int ni;
        rst_ni = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_word = 32'h0;
        out_ready = 1'b1;
        tick();
        tick();
        rst_ni = 1'b1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_word", 64'(out_word), 64'd0);
        chk("rst_out_idx", 64'(out_idx), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);

        // "abc" with continuous flow, start pulsed mid-expansion and on done.
        set_abc();
        run_block("abc", 1'b0, 1'b1);
        chk("abc_w16", 64'(got[16]), 64'h6162_6380);
        chk("abc_w17", 64'(got[17]), 64'h000F_0000);
        chk("abc_w18", 64'(got[18]), 64'h7DA8_6405);
        chk("abc_w15", 64'(got[15]), 64'h0000_0018);

        // Same block with random output stalls.
        run_block("abc_stall", 1'b1, 1'b0);
        chk("stall_w18", 64'(got[18]), 64'h7DA8_6405);

        // Abort at t=30 (W29 in the output slot).
        start = 1'b1;
        tick();
        start = 1'b0;
        ni = 0;
        for (int c = 0; c < 200; c++) begin
            in_valid = (ni < 16);
            if (ni < 16) in_word = msg[ni];
            out_ready = 1'b1;
            abort = out_valid && (out_idx == 6'd29);
            #1;
            if (in_valid && in_ready) ni++;
            tick();
            if (abort) break;
        end
        chk("abort_fired", 64'(abort), 64'd1);
        abort = 1'b0; in_valid = 1'b0;
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        tick();
        chk("abort_done_late", 64'(done), 64'd0);
        chk("abort_still_idle", 64'(busy), 64'd0);

        // Fresh block after abort; buffer is fully overwritten by the new load.
        for (int i = 0; i < 16; i++) msg[i] = 32'h0;
        msg[0] = 32'h1234_5678;
        msg[1] = 32'h0000_0008;
        run_block("blkb", 1'b1, 1'b0);
        chk("blkb_w16", 64'(got[16]), 64'h2236_5679);
        chk("blkb_w17", 64'(got[17]), 64'h0000_0008);

        // Reset during LOAD with t=7.
        set_abc();
        start = 1'b1;
        tick();
        start = 1'b0;
        ni = 0;
        for (int c = 0; c < 50; c++) begin
            in_valid = 1'b1;
            in_word = msg[ni];
            out_ready = 1'b1;
            #1;
            if (in_ready) ni++;
            tick();
            if (ni == 7) break;
        end
        chk("pre_rst_busy", 64'(busy), 64'd1);
        chk("pre_rst_idx", 64'(out_idx), 64'd6);
        rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1;
        chk("mrst_in_ready", 64'(in_ready), 64'd0);
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_out_word", 64'(out_word), 64'd0);
        chk("mrst_out_idx", 64'(out_idx), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_done", 64'(done), 64'd0);
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1;
            #1;
            chk("mrst_hold_ready", 64'(in_ready), 64'd0);
            tick();
            chk("mrst_hold_valid", 64'(out_valid), 64'd0);
            chk("mrst_hold_busy", 64'(busy), 64'd0);
        end
        in_valid = 1'b0;
        run_block("abc_post_rst", 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
